// File: rtl/cr16_reg_file.sv
// cr16_reg_file: CR16 general-purpose register file.
// Sixteen 16-bit registers loaded from one shared result bus under a
// (possibly multi-hot) enable vector, every register exposed in parallel,
// plus two combinational indexed read ports.
// Optional feature macro: CR16_REGFILE_BYPASS_EN -- when defined, a read
// port whose selected register is being written this cycle forwards the
// write bus instead of the stored value.
module cr16_reg_file #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 16,
    parameter int SEL_WIDTH  = 4
) (
    input  logic                  I_CLK,
    input  logic                  I_RESET,
    input  logic [DATA_WIDTH-1:0] I_REG_BUS,
    input  logic [NUM_REGS-1:0]   I_REG_ENABLE,
    output logic [DATA_WIDTH-1:0] O_REG_DATA [NUM_REGS],
    input  logic [SEL_WIDTH-1:0]  I_RD_A_SEL,
    output logic [DATA_WIDTH-1:0] O_RD_A_DATA,
    input  logic [SEL_WIDTH-1:0]  I_RD_B_SEL,
    output logic [DATA_WIDTH-1:0] O_RD_B_DATA
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Reset clears every register and wins over any enable; otherwise each
    // enabled register loads the shared bus and the rest hold.
    always_ff @(posedge I_CLK) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (I_RESET) begin
                regs[i] <= '0;
            end else if (I_REG_ENABLE[i]) begin
                regs[i] <= I_REG_BUS;
            end
        end
    end

    // The parallel output array is a straight copy of the flops.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            O_REG_DATA[i] = regs[i];
        end
    end

`ifdef CR16_REGFILE_BYPASS_EN
    // Read ports forward the bus when their register is written this cycle.
    always_comb begin
        O_RD_A_DATA = regs[I_RD_A_SEL];
        O_RD_B_DATA = regs[I_RD_B_SEL];
        if (!I_RESET && I_REG_ENABLE[I_RD_A_SEL]) begin
            O_RD_A_DATA = I_REG_BUS;
        end
        if (!I_RESET && I_REG_ENABLE[I_RD_B_SEL]) begin
            O_RD_B_DATA = I_REG_BUS;
        end
    end
`else
    // Read ports return stored values only; a same-cycle write shows up
    // after the next edge.
    always_comb begin
        O_RD_A_DATA = regs[I_RD_A_SEL];
        O_RD_B_DATA = regs[I_RD_B_SEL];
    end
`endif

endmodule

// File: tb/tb_cr16_reg_file.sv
// tb_cr16_reg_file: self-checking bench for cr16_reg_file.
// Directed steps followed by random cycles, all checked against a plain
// array model of the sixteen registers.
module tb_cr16_reg_file;

    logic        clk;
    logic        reset;
    logic [15:0] reg_bus;
    logic [15:0] reg_enable;
    logic [15:0] reg_data [16];
    logic [3:0]  rd_a_sel;
    logic [15:0] rd_a_data;
    logic [3:0]  rd_b_sel;
    logic [15:0] rd_b_data;

    logic [15:0] model [16];
    int          assertCount;
    int          failCount;

    cr16_reg_file #(
        .DATA_WIDTH(16),
        .NUM_REGS  (16),
        .SEL_WIDTH (4)
    ) dut (
        .I_CLK       (clk),
        .I_RESET     (reset),
        .I_REG_BUS   (reg_bus),
        .I_REG_ENABLE(reg_enable),
        .O_REG_DATA  (reg_data),
        .I_RD_A_SEL  (rd_a_sel),
        .O_RD_A_DATA (rd_a_data),
        .I_RD_B_SEL  (rd_b_sel),
        .O_RD_B_DATA (rd_b_data)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Value a read port should show for a given select, given the model and
    // the inputs currently applied.
    function automatic logic [15:0] portExpected(input logic [3:0] sel);
`ifdef CR16_REGFILE_BYPASS_EN
        if (!reset && reg_enable[sel]) return reg_bus;
`endif
        return model[sel];
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkPorts(input string tag);
        checkOutput({tag, " portA"}, rd_a_data, portExpected(rd_a_sel));
        checkOutput({tag, " portB"}, rd_b_data, portExpected(rd_b_sel));
    endtask

    task automatic checkAllRegs(input string tag);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("%s r%0d", tag, i), reg_data[i], model[i]);
        end
    endtask

    // Drive one cycle: apply inputs at the falling edge, check read ports
    // before the rising edge, advance the model, check everything after it.
    task automatic applyStimulus(input string tag, input logic rst,
                                 input logic [15:0] en, input logic [15:0] bus,
                                 input logic [3:0] asel, input logic [3:0] bsel,
                                 input bit checkRegs);
        @(negedge clk);
        reset      = rst;
        reg_enable = en;
        reg_bus    = bus;
        rd_a_sel   = asel;
        rd_b_sel   = bsel;
        #1;
        checkPorts({tag, " pre"});
        @(posedge clk);
        for (int i = 0; i < 16; i++) begin
            if (rst) model[i] = 16'h0000;
            else if (en[i]) model[i] = bus;
        end
        #1;
        checkPorts({tag, " post"});
        if (checkRegs) checkAllRegs(tag);
    endtask

    // Directed test plan followed by randomized traffic.
    initial begin
        logic [15:0] rndEn;
        assertCount = 0;
        failCount   = 0;
        reset       = 1'b1;
        reg_enable  = '0;
        reg_bus     = '0;
        rd_a_sel    = '0;
        rd_b_sel    = '0;
        for (int i = 0; i < 16; i++) model[i] = 16'h0000;

        applyStimulus("initReset", 1'b1, 16'h0000, 16'h0000, 4'd0, 4'd0, 1'b1);

        applyStimulus("fillOnes", 1'b0, 16'hFFFF, 16'hFFFF, 4'd1, 4'd14, 1'b1);
        applyStimulus("reset", 1'b1, 16'h0000, 16'h0000, 4'd1, 4'd14, 1'b1);

        for (int i = 0; i < 16; i++) begin
            applyStimulus($sformatf("walk%0d", i), 1'b0, 16'(1 << i),
                          16'(i * 1024), 4'(i), 4'(15 - i), 1'b1);
        end

        applyStimulus("holdWrite", 1'b0, 16'h0008, 16'h1234, 4'd3, 4'd4, 1'b1);
        applyStimulus("holdIdle", 1'b0, 16'h0000, 16'hDEAD, 4'd3, 4'd2, 1'b1);

        applyStimulus("multiHot", 1'b0, 16'h8001, 16'hBEEF, 4'd0, 4'd15, 1'b1);

        applyStimulus("resetPrio", 1'b1, 16'hFFFF, 16'h5555, 4'd7, 4'd9, 1'b1);

        applyStimulus("r5Load", 1'b0, 16'h0020, 16'h00A5, 4'd5, 4'd5, 1'b1);
        applyStimulus("r5Read", 1'b0, 16'h0000, 16'h0000, 4'd5, 4'd5, 1'b0);
        applyStimulus("r5Over", 1'b0, 16'h0020, 16'h7777, 4'd5, 4'd5, 1'b1);

        for (int n = 0; n < 200; n++) begin
            rndEn = 16'($urandom);
            if ($urandom_range(0, 3) == 0) rndEn = 16'(1 << $urandom_range(0, 15));
            applyStimulus($sformatf("rand%0d", n), ($urandom_range(0, 24) == 0),
                          rndEn, 16'($urandom), 4'($urandom), 4'($urandom),
                          (n % 4 == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
